smpl_iter_fsm: RTL and testbench
================================

# smpl_iter_fsm

Bounding-box sample iterator for the rasterizer. It accepts one triangle per handshake from the bounding-box stage (R13) and walks every subsample point of the triangle's axis-aligned box in raster order. It emits one candidate sample per cycle, with the triangle and color piped alongside, to the sample-test stage (R14). Its sample/valid/triangle stream is the producer side of what the sample-count scoreboard consumes and counts per triangle.

## Interface
- SIGFIG, 24, bits in color and position fixed-point values
- RADIX, 10, fraction bits in position
- VERTS, 3, vertices per triangle
- AXIS, 3, axes per vertex (x,y,z)
- COLORS, 3, color channels
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high, single clock domain
- tri_R13S  in  signed [SIGFIG-1:0] [VERTS][AXIS]  triangle vertices
- color_R13U  in  [SIGFIG-1:0] [COLORS]  triangle color
- box_R13S  in  signed [SIGFIG-1:0] [2][2]  box: [0]=lower-left (x,y), [1]=upper-right (x,y); pre-snapped to the sample grid
- validTri_R13H  in  1  triangle/box valid
- subSample_RnnnnU  in  4  one-hot subsample config
- halt_RnnnnL  out  1  0 = busy, upstream must hold R13 inputs
- tri_R14S  out  signed [SIGFIG-1:0] [VERTS][AXIS]  latched triangle
- color_R14U  out  [SIGFIG-1:0] [COLORS]  latched color
- sample_R14S  out  signed [SIGFIG-1:0] [2]  current sample (x,y)
- validSamp_R14H  out  1  sample_R14S valid
- lastSamp_R14H  out  1  final sample of the current triangle

## Operation
- ss_w_lg2 from subSample_RnnnnU: bit0→3, bit1→2, bit2→1, bit3→0. Step = 1 << (RADIX − ss_w_lg2). Step is latched at accept.
- States:
  - WAIT: halt_RnnnnL=1.
    - validTri_R13H=1 and box legal (UR.x ≥ LL.x and UR.y ≥ LL.y): latch tri, color, box and step; sample := LL; go to TEST.
    - Illegal box: drop the triangle, stay in WAIT, emit no samples.
  - TEST: validSamp_R14H=1 every cycle. Next sample is computed from the current one:
    - x+step ≤ UR.x → (x+step, y).
    - Otherwise, y+step ≤ UR.y → (LL.x, y+step).
    - Otherwise, current sample is last: lastSamp_R14H=1.
- On the last sample, halt_RnnnnL=1 (combinational from state registers).
  - validTri_R13H=1 that cycle with a legal box: accept directly and stay in TEST with the new triangle's LL.
  - Otherwise go to WAIT.
- Position add is done at SIGFIG+1 bits so the comparison never wraps. Boxes whose UR.x+step exceeds signed range still terminate correctly.
- tri_R14S, color_R14U and step stay constant for all samples of a triangle.
- subSample_RnnnnU changes are ignored mid-triangle.
- Sample count per triangle = ((UR.x−LL.x)/step + 1) × ((UR.y−LL.y)/step + 1).

## Timing
- Reset (rst=1 at a clk edge) gives state WAIT and these outputs:
  - validSamp_R14H=0, lastSamp_R14H=0, halt_RnnnnL=1.
  - sample_R14S, tri_R14S and color_R14U all 0.
- Reset mid-iteration abandons the triangle. No further samples are emitted.
- Accept at edge N (WAIT, halt_RnnnnL=1, validTri_R13H=1): first sample (LL) is valid in cycle N+1.
- A triangle of K samples occupies cycles N+1..N+K, with halt_RnnnnL=0 in N+1..N+K−1 and 1 in N+K.
- Back-to-back: a triangle accepted at the edge ending cycle N+K has its first sample in cycle N+K+1, with no bubble.
- Upstream must hold R13 inputs stable while halt_RnnnnL=0. The block samples them only when halt_RnnnnL=1.
- validTri_R13H while halt_RnnnnL=0 is ignored.
- No downstream backpressure; one sample per cycle unconditionally in TEST.

## Test plan
- Single sample, RADIX=10, subSample=4'b1000 (step 1024), box LL=(2048,3072), UR=(2048,3072):
  - One cycle with validSamp_R14H=1, lastSamp_R14H=1, sample (2048,3072).
  - halt_RnnnnL=1 throughout.
- Raster order, step 1024, box (0,0)-(2048,1024):
  - 6 consecutive valid samples: (0,0),(1024,0),(2048,0),(0,1024),(1024,1024),(2048,1024).
  - lastSamp_R14H only on the 6th; halt_RnnnnL=0 for the first 5.
- Fine subsample, subSample=4'b0001 (step 128), box (128,256)-(256,384):
  - Samples (128,256),(256,256),(128,384),(256,384), then WAIT.
- Back-to-back: triangle A (2 samples), with B (box (0,0)-(0,0)) held on validTri_R13H throughout:
  - Samples A0,A1,B0 in 3 consecutive cycles.
  - tri_R14S switches A→B exactly with B0; no gaps.
- Illegal box (UR.x < LL.x), then a legal 1-sample box:
  - No valid sample for the first box; the second box's sample appears 1 cycle after its accept.
- Reset mid-triangle: assert rst during sample 3 of a 6-sample box:
  - Next cycle validSamp_R14H=0, halt_RnnnnL=1, all data outputs 0.
  - A new triangle afterwards starts at its LL.

Source files
------------

// File: rtl/smpl_iter_fsm.sv
// -----------------------------------------------------------------------------
// smpl_iter_fsm
//
// Bounding-box sample iterator. It accepts one triangle (vertices, color and
// its pre-snapped axis-aligned bounding box) from the bounding-box stage and
// walks every subsample point of the box in raster order. This is x-major
// within a row, and rows run from bottom to top. It emits one candidate sample
// per cycle, and the latched triangle and color travel with each sample to the
// sample-test stage.
//
// Ports
//   clk               clock
//   rst               synchronous, active-high reset
//   tri_R13S          triangle vertices [VERTS][AXIS], signed fixed point
//   color_R13U        triangle color [COLORS]
//   box_R13S          bounding box: [0] = lower-left (x,y), [1] = upper-right
//   validTri_R13H     triangle/box valid
//   subSample_RnnnnU  one-hot subsample configuration (bit0 finest)
//   halt_RnnnnL       0 = busy; upstream must hold its R13 inputs stable
//   tri_R14S          latched triangle
//   color_R14U        latched color
//   sample_R14S       current sample position (x,y)
//   validSamp_R14H    sample_R14S is valid
//   lastSamp_R14H     final sample of the current triangle
// -----------------------------------------------------------------------------
module smpl_iter_fsm #(
   parameter int SIGFIG = 24,
   parameter int RADIX  = 10,
   parameter int VERTS  = 3,
   parameter int AXIS   = 3,
   parameter int COLORS = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [SIGFIG-1:0] tri_R13S   [VERTS][AXIS],
   input  logic        [SIGFIG-1:0] color_R13U [COLORS],
   input  logic signed [SIGFIG-1:0] box_R13S   [2][2],
   input  logic                     validTri_R13H,
   input  logic        [3:0]        subSample_RnnnnU,
   output logic                     halt_RnnnnL,
   output logic signed [SIGFIG-1:0] tri_R14S   [VERTS][AXIS],
   output logic        [SIGFIG-1:0] color_R14U [COLORS],
   output logic signed [SIGFIG-1:0] sample_R14S [2],
   output logic                     validSamp_R14H,
   output logic                     lastSamp_R14H
);

   // Positions are handled one bit wider than the interface, so that
   // coordinate + step can never wrap. This holds even when the box
   // touches the top of the signed range.
   localparam int PW = SIGFIG + 1;
   typedef logic signed [PW-1:0] pos_t;

   typedef enum logic {
      ST_WAIT,
      ST_TEST
   } state_t;

   state_t                   state_reg;
   pos_t                     step_reg;
   logic signed [SIGFIG-1:0] ll_x_reg;
   logic signed [SIGFIG-1:0] ur_x_reg;
   logic signed [SIGFIG-1:0] ur_y_reg;

   logic [1:0] ss_lg2;
   pos_t       step_in;
   logic       box_legal;
   logic       accept;
   logic       ld_last;

   pos_t cur_x, cur_y, ur_x, ur_y;
   pos_t adv_x, adv_y;
   pos_t nxt_x, nxt_y;
   logic nxt_last;

   // -------------------------------------------------------------------------
   // Incoming triangle: step size, legality and lastness of its first sample.
   // -------------------------------------------------------------------------
   always_comb begin
      ss_lg2 = 2'd0;
      if (subSample_RnnnnU[0])
         ss_lg2 = 2'd3;
      else if (subSample_RnnnnU[1])
         ss_lg2 = 2'd2;
      else if (subSample_RnnnnU[2])
         ss_lg2 = 2'd1;
      else if (subSample_RnnnnU[3])
         ss_lg2 = 2'd0;
   end

   assign step_in   = pos_t'(1) << (RADIX - int'(ss_lg2));
   assign box_legal = (box_R13S[1][0] >= box_R13S[0][0]) &&
                      (box_R13S[1][1] >= box_R13S[0][1]);

   // The block only looks at upstream while halted. That covers idle and
   // the last sample of a triangle, so back-to-back triangles have no bubble.
   assign halt_RnnnnL = (state_reg == ST_WAIT) || lastSamp_R14H;
   assign accept      = halt_RnnnnL && validTri_R13H && box_legal;

   // A 1-wide or 1-tall box can make the very first sample the last one.
   assign ld_last = ((pos_t'(box_R13S[0][0]) + step_in) > pos_t'(box_R13S[1][0])) &&
                    ((pos_t'(box_R13S[0][1]) + step_in) > pos_t'(box_R13S[1][1]));

   // -------------------------------------------------------------------------
   // Raster advance from the current sample, and whether that next sample
   // closes the box.
   // -------------------------------------------------------------------------
   assign cur_x = pos_t'(sample_R14S[0]);
   assign cur_y = pos_t'(sample_R14S[1]);
   assign ur_x  = pos_t'(ur_x_reg);
   assign ur_y  = pos_t'(ur_y_reg);
   assign adv_x = cur_x + step_reg;
   assign adv_y = cur_y + step_reg;

   always_comb begin
      nxt_x = adv_x;
      nxt_y = cur_y;
      if (adv_x > ur_x) begin
         nxt_x = pos_t'(ll_x_reg);
         nxt_y = adv_y;
      end
   end

   assign nxt_last = ((nxt_x + step_reg) > ur_x) && ((nxt_y + step_reg) > ur_y);

   // -------------------------------------------------------------------------
   // State, latched triangle and registered outputs.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_WAIT;
         step_reg       <= '0;
         ll_x_reg       <= '0;
         ur_x_reg       <= '0;
         ur_y_reg       <= '0;
         tri_R14S       <= '{default: '0};
         color_R14U     <= '{default: '0};
         sample_R14S    <= '{default: '0};
         validSamp_R14H <= 1'b0;
         lastSamp_R14H  <= 1'b0;
      end else if (accept) begin
         // Entered from WAIT or from the last sample of the previous triangle.
         state_reg      <= ST_TEST;
         step_reg       <= step_in;
         ll_x_reg       <= box_R13S[0][0];
         ur_x_reg       <= box_R13S[1][0];
         ur_y_reg       <= box_R13S[1][1];
         tri_R14S       <= tri_R13S;
         color_R14U     <= color_R13U;
         sample_R14S[0] <= box_R13S[0][0];
         sample_R14S[1] <= box_R13S[0][1];
         validSamp_R14H <= 1'b1;
         lastSamp_R14H  <= ld_last;
      end else begin
         case (state_reg)
            ST_TEST: begin
               if (lastSamp_R14H) begin
                  state_reg      <= ST_WAIT;
                  validSamp_R14H <= 1'b0;
                  lastSamp_R14H  <= 1'b0;
               end else begin
                  // The next sample is known to lie inside the box here,
                  // so dropping the guard bit is lossless.
                  sample_R14S[0] <= nxt_x[SIGFIG-1:0];
                  sample_R14S[1] <= nxt_y[SIGFIG-1:0];
                  validSamp_R14H <= 1'b1;
                  lastSamp_R14H  <= nxt_last;
               end
            end
            default: begin
               // Idle, or an illegal box was presented: emit nothing.
               state_reg      <= ST_WAIT;
               validSamp_R14H <= 1'b0;
               lastSamp_R14H  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_smpl_iter_fsm.sv
module tb_smpl_iter_fsm;

   localparam int SIGFIG = 24;
   localparam int RADIX  = 10;
   localparam longint SMAX = 8388607;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic signed [SIGFIG-1:0] tri_in  [3][3];
   logic        [SIGFIG-1:0] col_in  [3];
   logic signed [SIGFIG-1:0] box_in  [2][2];
   logic                     vt;
   logic        [3:0]        ss;
   logic                     halt;
   logic signed [SIGFIG-1:0] tri_out [3][3];
   logic        [SIGFIG-1:0] col_out [3];
   logic signed [SIGFIG-1:0] samp    [2];
   logic                     vs;
   logic                     ls;

   smpl_iter_fsm #(.SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(3), .AXIS(3), .COLORS(3)) dut (
      .clk              (clk),
      .rst              (rst),
      .tri_R13S         (tri_in),
      .color_R13U       (col_in),
      .box_R13S         (box_in),
      .validTri_R13H    (vt),
      .subSample_RnnnnU (ss),
      .halt_RnnnnL      (halt),
      .tri_R14S         (tri_out),
      .color_R14U       (col_out),
      .sample_R14S      (samp),
      .validSamp_R14H   (vs),
      .lastSamp_R14H    (ls)
   );

   int errors = 0;
   int checks = 0;
   bit en = 1'b0;

   task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------
   // Reference model: on each accepted triangle the full list of samples is
   // generated with nested loops. One entry is retired per clock. The head
   // of the queue is what the DUT must show, and a queue of size <= 1 means
   // the block is halted, so it is listening upstream.
   // ---------------------------------------------------------------------
   typedef struct {
      longint x;
      longint y;
   } smp_t;

   smp_t   q[$];
   longint m_tri [3][3];
   longint m_col [3];
   bit     m_halt;
   longint m_step;

   function automatic longint step_of(input logic [3:0] s);
      int lg;
      if (s[0])      lg = 3;
      else if (s[1]) lg = 2;
      else if (s[2]) lg = 1;
      else           lg = 0;
      return longint'(1) << (RADIX - lg);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         q.delete();
      end else begin
         m_halt = (q.size() <= 1);
         if (q.size() > 0) q.delete(0);
         if (m_halt && vt && box_in[1][0] >= box_in[0][0] && box_in[1][1] >= box_in[0][1]) begin
            m_step = step_of(ss);
            for (longint y = box_in[0][1]; y <= box_in[1][1]; y += m_step)
               for (longint x = box_in[0][0]; x <= box_in[1][0]; x += m_step)
                  q.push_back('{x: x, y: y});
            for (int v = 0; v < 3; v++)
               for (int a = 0; a < 3; a++)
                  m_tri[v][a] = tri_in[v][a];
            for (int c = 0; c < 3; c++) m_col[c] = col_in[c];
         end
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (en) begin
         chk("valid", vs, q.size() > 0);
         chk("last", ls, q.size() == 1);
         chk("halt", halt, q.size() <= 1);
         if (q.size() > 0) begin
            chk("sample_x", samp[0], q[0].x);
            chk("sample_y", samp[1], q[0].y);
            for (int v = 0; v < 3; v++)
               for (int a = 0; a < 3; a++)
                  chk("tri", tri_out[v][a], m_tri[v][a]);
            for (int c = 0; c < 3; c++) chk("color", col_out[c], m_col[c]);
         end
      end
   end

   task automatic set_tri(input int base);
      for (int v = 0; v < 3; v++)
         for (int a = 0; a < 3; a++)
            tri_in[v][a] = SIGFIG'(base + v * 3 + a);
      for (int c = 0; c < 3; c++) col_in[c] = SIGFIG'(base * 7 + c);
   endtask

   task automatic set_box(input longint llx, input longint lly, input longint urx, input longint ury);
      box_in[0][0] = SIGFIG'(llx);
      box_in[0][1] = SIGFIG'(lly);
      box_in[1][0] = SIGFIG'(urx);
      box_in[1][1] = SIGFIG'(ury);
   endtask

   int fx [4] = '{128, 256, 128, 256};
   int fy [4] = '{256, 256, 384, 384};

   initial begin
      longint st, llx, lly, urx, ury;
      int nx, ny;

      vt = 1'b0;
      ss = 4'b1000;
      set_tri(0);
      set_box(0, 0, 0, 0);
      rst = 1'b1;
      tick();
      tick();
      chk("rst_valid", vs, 0);
      chk("rst_last", ls, 0);
      chk("rst_halt", halt, 1);
      chk("rst_sx", samp[0], 0);
      chk("rst_sy", samp[1], 0);
      chk("rst_tri", tri_out[2][2], 0);
      chk("rst_color", col_out[0], 0);
      rst = 1'b0;
      en = 1'b1;

      // Single sample, step 1024.
      set_box(2048, 3072, 2048, 3072);
      set_tri(100);
      vt = 1'b1;
      chk("single_halt_idle", halt, 1);
      tick();
      vt = 1'b0;
      chk("single_valid", vs, 1);
      chk("single_last", ls, 1);
      chk("single_x", samp[0], 2048);
      chk("single_y", samp[1], 3072);
      chk("single_halt", halt, 1);
      tick();
      chk("single_done", vs, 0);

      // Raster order over a 3x2 box.
      set_box(0, 0, 2048, 1024);
      set_tri(200);
      vt = 1'b1;
      tick();
      vt = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk("raster_valid", vs, 1);
         chk("raster_x", samp[0], (i % 3) * 1024);
         chk("raster_y", samp[1], (i / 3) * 1024);
         chk("raster_last", ls, i == 5);
         chk("raster_halt", halt, i == 5);
         tick();
      end
      chk("raster_done", vs, 0);

      // Fine subsample, step 128.
      ss = 4'b0001;
      set_box(128, 256, 256, 384);
      vt = 1'b1;
      tick();
      vt = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("fine_x", samp[0], fx[i]);
         chk("fine_y", samp[1], fy[i]);
         chk("fine_last", ls, i == 3);
         tick();
      end
      chk("fine_done", vs, 0);
      ss = 4'b1000;

      // Back-to-back: A has 2 samples, B (1 sample) is held on the input.
      set_box(0, 0, 1024, 0);
      set_tri(300);
      vt = 1'b1;
      tick();
      chk("b2b_a0_x", samp[0], 0);
      chk("b2b_a0_tri", tri_out[0][0], 300);
      set_box(0, 0, 0, 0);
      set_tri(400);
      tick();
      chk("b2b_a1_valid", vs, 1);
      chk("b2b_a1_x", samp[0], 1024);
      chk("b2b_a1_tri", tri_out[0][0], 300);
      chk("b2b_a1_halt", halt, 1);
      tick();
      vt = 1'b0;
      chk("b2b_b0_valid", vs, 1);
      chk("b2b_b0_x", samp[0], 0);
      chk("b2b_b0_tri", tri_out[0][0], 400);
      chk("b2b_b0_last", ls, 1);
      tick();
      chk("b2b_done", vs, 0);

      // Illegal box is dropped, then a legal one follows one cycle later.
      set_box(2048, 0, 1024, 0);
      vt = 1'b1;
      tick();
      chk("illegal_valid", vs, 0);
      chk("illegal_halt", halt, 1);
      set_box(5120, -1024, 5120, -1024);
      set_tri(500);
      tick();
      vt = 1'b0;
      chk("legal_valid", vs, 1);
      chk("legal_x", samp[0], 5120);
      chk("legal_y", samp[1], -1024);
      tick();

      // Reset during sample 3 of a 6-sample box.
      set_box(0, 0, 2048, 1024);
      set_tri(600);
      vt = 1'b1;
      tick();
      vt = 1'b0;
      tick();
      tick();
      chk("mid_x", samp[0], 2048);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_valid", vs, 0);
      chk("mid_rst_halt", halt, 1);
      chk("mid_rst_sx", samp[0], 0);
      chk("mid_rst_sy", samp[1], 0);
      for (int v = 0; v < 3; v++)
         for (int a = 0; a < 3; a++)
            chk("mid_rst_tri", tri_out[v][a], 0);
      for (int c = 0; c < 3; c++) chk("mid_rst_color", col_out[c], 0);
      set_box(3072, 2048, 4096, 2048);
      set_tri(700);
      vt = 1'b1;
      tick();
      vt = 1'b0;
      chk("after_rst_x", samp[0], 3072);
      chk("after_rst_y", samp[1], 2048);
      chk("after_rst_last", ls, 0);
      tick();
      chk("after_rst_x2", samp[0], 4096);
      chk("after_rst_last2", ls, 1);
      tick();

      // Upper-right x at the top of the signed range.
      set_box(SMAX - 1029, 0, SMAX, 0);
      vt = 1'b1;
      tick();
      vt = 1'b0;
      chk("edge_x0", samp[0], SMAX - 1029);
      chk("edge_last0", ls, 0);
      tick();
      chk("edge_x1", samp[0], SMAX - 5);
      chk("edge_last1", ls, 1);
      tick();
      chk("edge_done", vs, 0);

      // Randomized traffic; R13 inputs only change while the model is halted.
      for (int n = 0; n < 3000; n++) begin
         if (q.size() <= 1) begin
            vt = ($urandom_range(0, 9) < 7);
            ss = 4'b0001 << $urandom_range(0, 3);
            st = step_of(ss);
            nx = int'($urandom_range(0, 3));
            ny = int'($urandom_range(0, 3));
            llx = longint'(int'($urandom_range(0, 400)) - 200) * st;
            lly = longint'(int'($urandom_range(0, 400)) - 200) * st;
            urx = llx + nx * st + (($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 127)) : 0);
            ury = lly + ny * st;
            if ($urandom_range(0, 19) == 0) begin
               urx = SMAX;
               llx = SMAX - nx * st - longint'($urandom_range(0, 127));
            end
            if ($urandom_range(0, 6) == 0) urx = llx - 1 - longint'($urandom_range(0, 2000));
            if ($urandom_range(0, 12) == 0) ury = lly - 1 - longint'($urandom_range(0, 2000));
            set_box(llx, lly, urx, ury);
            for (int v = 0; v < 3; v++)
               for (int a = 0; a < 3; a++)
                  tri_in[v][a] = SIGFIG'($urandom);
            for (int c = 0; c < 3; c++) col_in[c] = SIGFIG'($urandom);
         end else begin
            ss = 4'b0001 << $urandom_range(0, 3);
         end
         rst = ($urandom_range(0, 249) == 0);
         tick();
      end
      rst = 1'b0;
      vt = 1'b0;
      repeat (40) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
